mc_control_fsm: RTL and testbench
=================================

# mc_control_fsm

Multi-cycle main control FSM for the RISC-V core, replacing the single-cycle decoder's flat control with a sequenced FETCH/DECODE/EXEC/MEM/WB flow. It shares one memory port between instruction fetch and data access, through a req/ready handshake with a bounded wait. It drives every datapath enable and mux select: PC, IR, data register, register file, ALU operand and operation selects, and writeback select. The immediate generator is decoded from the same latched instruction.

## Interface
- MEM_TIMEOUT, 16: maximum cycles a memory request may wait for mem_ready before a bus error (legal 2..255).
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- instr  in  32  latched instruction register contents, valid from DECODE onward
- mem_ready  in  1  memory accepted/completed current request this cycle
- br_taken  in  1  branch comparison result from ALU, valid in EXEC
- mem_req  out  1  memory request, held until mem_ready
- mem_we  out  1  1 = store, 0 = read (fetch or load)
- ir_we  out  1  latch fetched word into IR
- mdr_we  out  1  latch load data into data register
- pc_we  out  1  update PC
- pc_sel  out  2  0 = PC+4, 1 = PC+imm, 2 = ALU result with bit0 cleared
- rf_we  out  1  register-file write enable
- wb_sel  out  2  0 = ALU, 1 = data register, 2 = PC+4, 3 = imm
- alu_a_sel  out  1  0 = rs1, 1 = PC
- alu_b_sel  out  1  0 = rs2, 1 = imm
- alu_op  out  2  0 = add, 1 = funct3/funct7 decoded, 2 = branch compare
- bus_err  out  1  sticky, memory timeout occurred
- illegal  out  1  sticky, unsupported opcode decoded
- state  out  3  current state encoding, debug

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5. Encodings 6 and 7 go to FETCH.
- Any output not listed for a state is 0.
- FETCH:
  - mem_req=1, mem_we=0.
  - On mem_ready: ir_we=1, go to DECODE.
- DECODE:
  - Legal opcodes are 0x33, 0x13, 0x03, 0x23, 0x63, 0x6F, 0x67, 0x37, 0x17.
  - Legal opcode: go to EXEC. Anything else: set illegal, go to TRAP.
- EXEC, by opcode:
  - 0x33: alu_op=1, a=rs1, b=rs2, rf_we=1, wb_sel=0, pc_we=1, pc_sel=0, go to FETCH.
  - 0x13: as 0x33 but b=imm.
  - 0x37 (LUI): rf_we=1, wb_sel=3, pc_we=1, pc_sel=0, go to FETCH.
  - 0x17 (AUIPC): a=PC, b=imm, alu_op=0, rf_we=1, wb_sel=0, pc_we=1, pc_sel=0, go to FETCH.
  - 0x6F (JAL): rf_we=1, wb_sel=2, pc_we=1, pc_sel=1, go to FETCH.
  - 0x67 (JALR): a=rs1, b=imm, alu_op=0, rf_we=1, wb_sel=2, pc_we=1, pc_sel=2, go to FETCH.
  - 0x63 (branch): a=rs1, b=rs2, alu_op=2, pc_we=1, pc_sel = br_taken ? 1 : 0, go to FETCH.
  - 0x03 / 0x23 (load/store): a=rs1, b=imm, alu_op=0, go to MEM.
- MEM:
  - ALU selects held as in EXEC; mem_req=1, mem_we = (opcode==0x23).
  - On mem_ready, store: pc_we=1, pc_sel=0, go to FETCH.
  - On mem_ready, load: mdr_we=1, go to WB.
- WB: rf_we=1, wb_sel=1, pc_we=1, pc_sel=0, go to FETCH.
- TRAP: all enables 0, mem_req=0. Stays in TRAP until rst.
- rf_we is forced to 0 when instr[11:7]==0 (x0 writes suppressed).
- Timeout counter (8-bit):
  - Cleared on entry to FETCH or MEM.
  - Increments each FETCH/MEM cycle without mem_ready.
  - If the count reaches MEM_TIMEOUT-1 while mem_ready is low: set bus_err, go to TRAP.
  - mem_ready on that same cycle wins: normal transition, no error.

## Timing
- During and after a cycle with rst=1: state=FETCH, illegal=0, bus_err=0, counter=0.
- All outputs in the rst cycle are 0.
- The first post-reset cycle has mem_req=1.
- Moore outputs depend on state and instr only: mem_req, mem_we, selects, rf_we, and pc_we outside branch.
- Mealy outputs also depend on inputs: ir_we and mdr_we on mem_ready; pc_sel in a branch EXEC on br_taken.
- Handshake:
  - mem_req and mem_we are stable from assertion until the mem_ready cycle inclusive. The request is never withdrawn except by rst or timeout.
  - mem_ready is ignored outside FETCH/MEM.
- Cycles per instruction with zero-wait memory (mem_ready=1 in the first request cycle):
  - R/I/LUI/AUIPC/JAL/JALR/branch: 3.
  - Store: 4.
  - Load: 5.
- Each wait cycle adds 1.
- rst mid-instruction aborts immediately with no enables in that cycle. An in-flight request is dropped.

## Test plan
- Reset, then addi x1,x0,5 (0x00500093) with mem_ready tied 1 → states 0,1,2,0. In EXEC: rf_we=1, alu_b_sel=1, alu_op=1, pc_we=1, pc_sel=0.
- lw x2,0(x1) (0x0000A103) with 2 wait cycles in MEM → 7 cycles total. mdr_we pulses in the ready cycle; WB has rf_we=1, wb_sel=1.
- sw x2,4(x1) (0x0020A223) → MEM has mem_we=1. No rf_we in any cycle. Returns to FETCH after 4 cycles.
- beq x0,x0,8 (0x00000463) → EXEC pc_sel=1 with br_taken=1 and pc_sel=0 with br_taken=0; rf_we=0 in both.
- instr=0x00000000 → illegal=1 after DECODE, state=5, and all enables stay 0 for 20 cycles until rst.
- mem_ready held 0 in FETCH → bus_err=1 and TRAP exactly after 15 waiting cycles with MEM_TIMEOUT=16. mem_ready=1 on cycle 15 instead → no error, go to DECODE.

Source files
------------

// File: rtl/mc_control_fsm_if.sv
// rtl/mc_control_fsm_if.sv - shared memory port handshake between control FSM and memory
//
// Purpose: groups the single memory port's request/response handshake so the
// control FSM (master) and the memory or its model (slave) connect with one port.
//
// Signals:
//   mem_req    master -> slave  request active, held until mem_ready
//   mem_we     master -> slave  1 = store, 0 = read (fetch or load)
//   mem_ready  slave -> master  request accepted/completed this cycle
interface mc_control_fsm_if;
  logic mem_req;
  logic mem_we;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    output mem_ready
  );
endinterface

// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - multi-cycle main control FSM for the RISC-V core
//
// Purpose: sequences FETCH/DECODE/EXEC/MEM/WB over one shared memory port and
// drives every datapath enable and mux select from the state and latched IR.
//
// Ports:
//   clk          system clock, all state on the rising edge
//   rst          synchronous active-high reset
//   bus          memory handshake (master side): mem_req, mem_we, mem_ready
//   instr_i      latched instruction register, valid from DECODE onward
//   br_taken_i   branch comparison result, used in a branch EXEC
//   ir_we_o      latch fetched word into IR
//   mdr_we_o     latch load data into the data register
//   pc_we_o      update PC
//   pc_sel_o     0 = PC+4, 1 = PC+imm, 2 = ALU result with bit0 cleared
//   rf_we_o      register-file write enable (suppressed for rd = x0)
//   wb_sel_o     0 = ALU, 1 = data register, 2 = PC+4, 3 = imm
//   alu_a_sel_o  0 = rs1, 1 = PC
//   alu_b_sel_o  0 = rs2, 1 = imm
//   alu_op_o     0 = add, 1 = funct3/funct7 decoded, 2 = branch compare
//   bus_err_o    sticky memory timeout flag
//   illegal_o    sticky unsupported-opcode flag
//   state_o      current state encoding (debug)
module mc_control_fsm #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  mc_control_fsm_if.master        bus,
  input  logic [31:0]             instr_i,
  input  logic                    br_taken_i,
  output logic                    ir_we_o,
  output logic                    mdr_we_o,
  output logic                    pc_we_o,
  output logic [1:0]              pc_sel_o,
  output logic                    rf_we_o,
  output logic [1:0]              wb_sel_o,
  output logic                    alu_a_sel_o,
  output logic                    alu_b_sel_o,
  output logic [1:0]              alu_op_o,
  output logic                    bus_err_o,
  output logic                    illegal_o,
  output logic [2:0]              state_o
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  localparam logic [6:0] OP_R     = 7'h33;
  localparam logic [6:0] OP_I     = 7'h13;
  localparam logic [6:0] OP_LOAD  = 7'h03;
  localparam logic [6:0] OP_STORE = 7'h23;
  localparam logic [6:0] OP_BR    = 7'h63;
  localparam logic [6:0] OP_JAL   = 7'h6F;
  localparam logic [6:0] OP_JALR  = 7'h67;
  localparam logic [6:0] OP_LUI   = 7'h37;
  localparam logic [6:0] OP_AUIPC = 7'h17;

  // The counter holds the number of completed wait cycles. The request times
  // out in the cycle whose increment would make it reach MEM_TIMEOUT-1, so a
  // request lives at most MEM_TIMEOUT-1 cycles.
  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 2);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       bus_err_q, bus_err_d;
  logic       illegal_q, illegal_d;

  logic [6:0] opcode;
  logic       rd_is_x0;
  logic       op_legal;
  logic       timeout_hit;

  logic       mem_req;
  logic       mem_we;
  logic       rf_we;

  // Only the opcode and rd fields matter to control; the rest feeds the datapath.
  logic       unused_instr_bits;
  assign unused_instr_bits = ^instr_i[31:12];

  assign opcode      = instr_i[6:0];
  assign rd_is_x0    = (instr_i[11:7] == 5'd0);
  assign timeout_hit = (cnt_q == TIMEOUT_LAST);

  always_comb begin
    op_legal = 1'b0;
    case (opcode)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_BR,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: op_legal = 1'b1;
      default:                           op_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      cnt_q     <= 8'd0;
      bus_err_q <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    // Counter returns to zero whenever we are not waiting, so every entry
    // into FETCH or MEM starts from a clean count.
    cnt_d       = 8'd0;
    bus_err_d   = bus_err_q;
    illegal_d   = illegal_q;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    ir_we_o     = 1'b0;
    mdr_we_o    = 1'b0;
    pc_we_o     = 1'b0;
    pc_sel_o    = 2'd0;
    rf_we       = 1'b0;
    wb_sel_o    = 2'd0;
    alu_a_sel_o = 1'b0;
    alu_b_sel_o = 1'b0;
    alu_op_o    = 2'd0;

    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (bus.mem_ready) begin
          ir_we_o = 1'b1;
          state_d = S_DECODE;
        end else if (timeout_hit) begin
          bus_err_d = 1'b1;
          state_d   = S_TRAP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      S_DECODE: begin
        if (op_legal) begin
          state_d = S_EXEC;
        end else begin
          illegal_d = 1'b1;
          state_d   = S_TRAP;
        end
      end

      S_EXEC: begin
        state_d = S_FETCH;
        case (opcode)
          OP_R: begin
            alu_op_o = 2'd1;
            rf_we    = 1'b1;
            pc_we_o  = 1'b1;
          end
          OP_I: begin
            alu_op_o    = 2'd1;
            alu_b_sel_o = 1'b1;
            rf_we       = 1'b1;
            pc_we_o     = 1'b1;
          end
          OP_LUI: begin
            rf_we    = 1'b1;
            wb_sel_o = 2'd3;
            pc_we_o  = 1'b1;
          end
          OP_AUIPC: begin
            alu_a_sel_o = 1'b1;
            alu_b_sel_o = 1'b1;
            rf_we       = 1'b1;
            pc_we_o     = 1'b1;
          end
          OP_JAL: begin
            rf_we    = 1'b1;
            wb_sel_o = 2'd2;
            pc_we_o  = 1'b1;
            pc_sel_o = 2'd1;
          end
          OP_JALR: begin
            alu_b_sel_o = 1'b1;
            rf_we       = 1'b1;
            wb_sel_o    = 2'd2;
            pc_we_o     = 1'b1;
            pc_sel_o    = 2'd2;
          end
          OP_BR: begin
            alu_op_o = 2'd2;
            pc_we_o  = 1'b1;
            pc_sel_o = br_taken_i ? 2'd1 : 2'd0;
          end
          OP_LOAD, OP_STORE: begin
            alu_b_sel_o = 1'b1;
            state_d     = S_MEM;
          end
          default: begin
            // IR changed under us after DECODE; treat it as unsupported.
            illegal_d = 1'b1;
            state_d   = S_TRAP;
          end
        endcase
      end

      S_MEM: begin
        // Address computation (rs1 + imm) stays selected for the whole access.
        alu_b_sel_o = 1'b1;
        mem_req     = 1'b1;
        mem_we      = (opcode == OP_STORE);
        if (bus.mem_ready) begin
          if (opcode == OP_STORE) begin
            pc_we_o = 1'b1;
            state_d = S_FETCH;
          end else begin
            mdr_we_o = 1'b1;
            state_d  = S_WB;
          end
        end else if (timeout_hit) begin
          bus_err_d = 1'b1;
          state_d   = S_TRAP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      S_WB: begin
        rf_we    = 1'b1;
        wb_sel_o = 2'd1;
        pc_we_o  = 1'b1;
        state_d  = S_FETCH;
      end

      S_TRAP: begin
        state_d = S_TRAP;
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase

    // Reset cycle: abort whatever is in flight with no side effects at all.
    if (rst) begin
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      ir_we_o     = 1'b0;
      mdr_we_o    = 1'b0;
      pc_we_o     = 1'b0;
      pc_sel_o    = 2'd0;
      rf_we       = 1'b0;
      wb_sel_o    = 2'd0;
      alu_a_sel_o = 1'b0;
      alu_b_sel_o = 1'b0;
      alu_op_o    = 2'd0;
    end
  end

  // Writes to x0 are architecturally discarded; suppress them at the source.
  assign rf_we_o     = rf_we & ~rd_is_x0;
  assign bus.mem_req = mem_req;
  assign bus.mem_we  = mem_we;

  assign bus_err_o = bus_err_q & ~rst;
  assign illegal_o = illegal_q & ~rst;
  assign state_o   = rst ? 3'd0 : 3'(state_q);

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb/tb_mc_control_fsm.sv - self-checking bench for mc_control_fsm
module tb_mc_control_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        br_taken;
  logic        ir_we, mdr_we, pc_we, rf_we, alu_a_sel, alu_b_sel, bus_err, illegal;
  logic [1:0]  pc_sel, wb_sel, alu_op;
  logic [2:0]  state;

  always #5 clk = ~clk;

  mc_control_fsm_if bus();

  mc_control_fsm #(.MEM_TIMEOUT(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .instr_i     (instr),
    .br_taken_i  (br_taken),
    .ir_we_o     (ir_we),
    .mdr_we_o    (mdr_we),
    .pc_we_o     (pc_we),
    .pc_sel_o    (pc_sel),
    .rf_we_o     (rf_we),
    .wb_sel_o    (wb_sel),
    .alu_a_sel_o (alu_a_sel),
    .alu_b_sel_o (alu_b_sel),
    .alu_op_o    (alu_op),
    .bus_err_o   (bus_err),
    .illegal_o   (illegal),
    .state_o     (state)
  );

  typedef struct packed {
    logic [2:0] st;
    logic       req;
    logic       we;
    logic       irw;
    logic       mdrw;
    logic       pcw;
    logic [1:0] pcs;
    logic       rfw;
    logic [1:0] wbs;
    logic       a;
    logic       b;
    logic [1:0] aop;
    logic       berr;
    logic       ill;
  } outs_t;

  typedef struct packed {
    outs_t o;
    logic  mr;
    logic  br;
  } step_t;

  step_t tr[$];
  int    checks = 0;
  int    errors = 0;

  function automatic outs_t sample();
    return {state, bus.mem_req, bus.mem_we, ir_we, mdr_we, pc_we, pc_sel,
            rf_we, wb_sel, alu_a_sel, alu_b_sel, alu_op, bus_err, illegal};
  endfunction

  task automatic drive_step(input step_t s, output outs_t o);
    bus.mem_ready = s.mr;
    br_taken      = s.br;
    @(negedge clk);
    o = sample();
    @(posedge clk);
    #1;
  endtask

  function automatic bit legal_op(input logic [6:0] op);
    return op inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
  endfunction

  // Reference: per-cycle expected outputs for one instruction, from the
  // instruction-class table. fw/mw = wait cycles before mem_ready in FETCH/MEM.
  task automatic build_instr(input logic [31:0] ins, input int fw, input int mw, input logic brt);
    logic [6:0] opc;
    logic       wr;
    step_t      s;
    opc = ins[6:0];
    wr  = (ins[11:7] != 5'd0);
    repeat (fw) begin
      s = '0; s.o.req = 1'b1; s.br = 1'($urandom); tr.push_back(s);
    end
    s = '0; s.o.req = 1'b1; s.o.irw = 1'b1; s.mr = 1'b1; s.br = 1'($urandom);
    tr.push_back(s);
    s = '0; s.o.st = 3'd1; s.mr = 1'($urandom); s.br = 1'($urandom);
    tr.push_back(s);
    if (!legal_op(opc)) return;
    s = '0; s.o.st = 3'd2; s.mr = 1'($urandom); s.br = brt;
    case (opc)
      7'h33: begin s.o.aop = 2'd1; s.o.rfw = wr; s.o.pcw = 1'b1; end
      7'h13: begin s.o.aop = 2'd1; s.o.b = 1'b1; s.o.rfw = wr; s.o.pcw = 1'b1; end
      7'h37: begin s.o.rfw = wr; s.o.wbs = 2'd3; s.o.pcw = 1'b1; end
      7'h17: begin s.o.a = 1'b1; s.o.b = 1'b1; s.o.rfw = wr; s.o.pcw = 1'b1; end
      7'h6F: begin s.o.rfw = wr; s.o.wbs = 2'd2; s.o.pcw = 1'b1; s.o.pcs = 2'd1; end
      7'h67: begin s.o.b = 1'b1; s.o.rfw = wr; s.o.wbs = 2'd2; s.o.pcw = 1'b1; s.o.pcs = 2'd2; end
      7'h63: begin s.o.aop = 2'd2; s.o.pcw = 1'b1; s.o.pcs = brt ? 2'd1 : 2'd0; end
      default: s.o.b = 1'b1;
    endcase
    tr.push_back(s);
    if (opc == 7'h03 || opc == 7'h23) begin
      repeat (mw) begin
        s = '0; s.o.st = 3'd3; s.o.req = 1'b1; s.o.we = (opc == 7'h23); s.o.b = 1'b1;
        s.br = 1'($urandom); tr.push_back(s);
      end
      s = '0; s.o.st = 3'd3; s.o.req = 1'b1; s.o.we = (opc == 7'h23); s.o.b = 1'b1;
      s.mr = 1'b1; s.br = 1'($urandom);
      if (opc == 7'h23) s.o.pcw = 1'b1;
      else              s.o.mdrw = 1'b1;
      tr.push_back(s);
      if (opc == 7'h03) begin
        s = '0; s.o.st = 3'd4; s.o.rfw = wr; s.o.wbs = 2'd1; s.o.pcw = 1'b1;
        s.mr = 1'($urandom); s.br = 1'($urandom); tr.push_back(s);
      end
    end
  endtask

  task automatic push_trap(input int n, input logic berr, input logic ill);
    step_t s;
    repeat (n) begin
      s = '0; s.o.st = 3'd5; s.o.berr = berr; s.o.ill = ill;
      s.mr = 1'($urandom); s.br = 1'($urandom); tr.push_back(s);
    end
  endtask

  task automatic test_reset();
    outs_t obs;
    rst = 1'b1; bus.mem_ready = 1'b1; br_taken = 1'b1; instr = 32'h00500093;
    repeat (2) begin
      @(negedge clk);
      obs = sample();
      checks++;
      if (obs !== outs_t'(0)) begin
        errors++; $display("FAIL reset: got %h expected %h", obs, outs_t'(0));
      end
      @(posedge clk); #1;
    end
    rst = 1'b0;
  endtask

  task automatic test_addi();
    step_t s; outs_t obs; int n = 0;
    instr = 32'h00500093;
    build_instr(instr, 0, 0, 1'b0);
    while (tr.size() > 0) begin
      s = tr.pop_front(); drive_step(s, obs); checks++;
      if (obs !== s.o) begin errors++; $display("FAIL addi cycle %0d: got %h expected %h", n, obs, s.o); end
      n++;
    end
  endtask

  task automatic test_load();
    step_t s; outs_t obs; int n = 0;
    instr = 32'h0000A103;
    build_instr(instr, 0, 2, 1'b0);
    if (tr.size() != 7) begin errors++; $display("FAIL load_len: got %0d expected 7", tr.size()); end
    checks++;
    while (tr.size() > 0) begin
      s = tr.pop_front(); drive_step(s, obs); checks++;
      if (obs !== s.o) begin errors++; $display("FAIL load cycle %0d: got %h expected %h", n, obs, s.o); end
      n++;
    end
  endtask

  task automatic test_store();
    step_t s; outs_t obs; int n = 0;
    instr = 32'h0020A223;
    build_instr(instr, 0, 0, 1'b0);
    while (tr.size() > 0) begin
      s = tr.pop_front(); drive_step(s, obs); checks++;
      if (obs !== s.o) begin errors++; $display("FAIL store cycle %0d: got %h expected %h", n, obs, s.o); end
      n++;
    end
  endtask

  task automatic test_branch();
    step_t s; outs_t obs; int n = 0;
    instr = 32'h00000463;
    build_instr(instr, 0, 0, 1'b1);
    build_instr(instr, 1, 0, 1'b0);
    while (tr.size() > 0) begin
      s = tr.pop_front(); drive_step(s, obs); checks++;
      if (obs !== s.o) begin errors++; $display("FAIL branch cycle %0d: got %h expected %h", n, obs, s.o); end
      n++;
    end
  endtask

  task automatic test_timeout();
    step_t s; outs_t obs; int n = 0;
    instr = 32'h00500093;
    repeat (15) begin
      s = '0; s.o.req = 1'b1; s.br = 1'($urandom); tr.push_back(s);
    end
    push_trap(4, 1'b1, 1'b0);
    while (tr.size() > 0) begin
      s = tr.pop_front(); drive_step(s, obs); checks++;
      if (obs !== s.o) begin errors++; $display("FAIL timeout cycle %0d: got %h expected %h", n, obs, s.o); end
      n++;
    end
    rst = 1'b1; bus.mem_ready = 1'b1;
    @(negedge clk);
    obs = sample(); checks++;
    if (obs !== outs_t'(0)) begin errors++; $display("FAIL timeout_rst: got %h expected %h", obs, outs_t'(0)); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_timeout_recover();
    step_t s; outs_t obs; int n = 0;
    instr = 32'h00500093;
    build_instr(instr, 14, 0, 1'b0);
    while (tr.size() > 0) begin
      s = tr.pop_front(); drive_step(s, obs); checks++;
      if (obs !== s.o) begin errors++; $display("FAIL timeout_recover cycle %0d: got %h expected %h", n, obs, s.o); end
      n++;
    end
  endtask

  task automatic test_illegal();
    step_t s; outs_t obs; int n = 0;
    instr = 32'h00000000;
    build_instr(instr, 0, 0, 1'b0);
    push_trap(20, 1'b0, 1'b1);
    while (tr.size() > 0) begin
      s = tr.pop_front(); drive_step(s, obs); checks++;
      if (obs !== s.o) begin errors++; $display("FAIL illegal cycle %0d: got %h expected %h", n, obs, s.o); end
      n++;
    end
    rst = 1'b1; bus.mem_ready = 1'b0;
    @(negedge clk);
    obs = sample(); checks++;
    if (obs !== outs_t'(0)) begin errors++; $display("FAIL illegal_rst: got %h expected %h", obs, outs_t'(0)); end
    @(posedge clk); #1;
    rst = 1'b0;
    instr = 32'h00500093;
    build_instr(instr, 0, 0, 1'b0);
    n = 0;
    while (tr.size() > 0) begin
      s = tr.pop_front(); drive_step(s, obs); checks++;
      if (obs !== s.o) begin errors++; $display("FAIL illegal_clear cycle %0d: got %h expected %h", n, obs, s.o); end
      n++;
    end
  endtask

  task automatic test_reset_mid();
    step_t s; outs_t obs; int n = 0;
    instr = 32'h0000A103;
    build_instr(instr, 1, 3, 1'b0);
    while (tr.size() > 0 && tr[0].o.st != 3'd3) begin
      s = tr.pop_front(); drive_step(s, obs); checks++;
      if (obs !== s.o) begin errors++; $display("FAIL reset_mid cycle %0d: got %h expected %h", n, obs, s.o); end
      n++;
    end
    tr.delete();
    rst = 1'b1; bus.mem_ready = 1'b1;
    @(negedge clk);
    obs = sample(); checks++;
    if (obs !== outs_t'(0)) begin errors++; $display("FAIL reset_mid_abort: got %h expected %h", obs, outs_t'(0)); end
    @(posedge clk); #1;
    rst = 1'b0;
    instr = 32'h00500093;
    build_instr(instr, 0, 0, 1'b0);
    n = 0;
    while (tr.size() > 0) begin
      s = tr.pop_front(); drive_step(s, obs); checks++;
      if (obs !== s.o) begin errors++; $display("FAIL reset_mid_restart cycle %0d: got %h expected %h", n, obs, s.o); end
      n++;
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0]  ops [9];
    logic [31:0] ins;
    step_t       s;
    outs_t       obs;
    int          n;
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
    for (int k = 0; k < 40; k++) begin
      ins = $urandom();
      ins[6:0] = ops[$urandom_range(0, 8)];
      if ($urandom_range(0, 3) == 0) ins[11:7] = 5'd0;
      instr = ins;
      build_instr(ins, $urandom_range(0, 4), $urandom_range(0, 4), 1'($urandom));
      n = 0;
      while (tr.size() > 0) begin
        s = tr.pop_front(); drive_step(s, obs); checks++;
        if (obs !== s.o) begin
          errors++;
          $display("FAIL back_to_back instr %0d (%h) cycle %0d: got %h expected %h", k, ins, n, obs, s.o);
        end
        n++;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    instr = 32'h0;
    br_taken = 1'b0;
    bus.mem_ready = 1'b0;
    test_reset();
    test_addi();
    test_load();
    test_store();
    test_branch();
    test_timeout();
    test_timeout_recover();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
